// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : instruction_fetch_unit                                          |
// | Purpose  : Fetch stage. Issues word reads over a req/gnt/rvalid handshake, |
// |            queues returned words with their PCs in a DEPTH-entry prefetch  |
// |            queue and hands them to decode with valid/ready. A redirect     |
// |            flushes the queue and drops every in-flight stale response.     |
// | Options  : `define IFU_BYPASS_EN enables the zero-latency rvalid-to-decode |
// |            bypass while the queue is empty.                                |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module instruction_fetch_unit #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_in,
  input  logic        pc_load,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  input  logic        id_ready
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_SUM = (CNT_W + 1)'(DEPTH);

  typedef enum logic [0:0] {
    ST_FETCH = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  state_e             state_q,    state_d;
  logic [31:0]        fetch_pc_q, fetch_pc_d;
  logic [31:0]        resp_pc_q,  resp_pc_d;
  logic [31:0]        instr_mem_q [DEPTH];
  logic [31:0]        instr_mem_d [DEPTH];
  logic [31:0]        pc_mem_q    [DEPTH];
  logic [31:0]        pc_mem_d    [DEPTH];
  logic [PTR_W-1:0]   head_q,     head_d;
  logic [PTR_W-1:0]   tail_q,     tail_d;
  logic [CNT_W-1:0]   count_q,    count_d;
  logic [CNT_W-1:0]   outst_q,    outst_d;
  logic [CNT_W-1:0]   discard_q,  discard_d;
  logic               started_q,  started_d;

  logic               issue;
  logic               rvalid_acc;
  logic               head_valid;
  logic               bypass;
  logic               accept;
  logic               push;
  logic               pop;
  logic [31:0]        target;

  // Bypass hands an arriving word straight to decode when nothing is queued ahead of it.
  always_comb begin
`ifdef IFU_BYPASS_EN
    bypass = (state_q == ST_FETCH) && (count_q == '0) && rvalid_acc && !pc_load;
`else
    bypass = 1'b0;
`endif
  end

  // Handshake qualifiers, credit-limited request and decode-side outputs (idle-zero when not valid).
  always_comb begin
    imem_req   = started_q && (state_q == ST_FETCH) &&
                 (({1'b0, count_q} + {1'b0, outst_q}) < DEPTH_SUM);
    imem_addr  = fetch_pc_q;
    issue      = imem_req && imem_gnt;
    rvalid_acc = imem_rvalid && (outst_q != '0);
    head_valid = (count_q != '0);
    accept     = (state_q == ST_FETCH) && rvalid_acc && !pc_load;
    push       = accept && !(bypass && id_ready);
    pop        = head_valid && id_ready;
    target     = pc_in & 32'hFFFF_FFFC;
    id_valid   = head_valid || bypass;
    id_instr   = 32'h0;
    id_pc      = 32'h0;
    if (head_valid) begin
      id_instr = instr_mem_q[head_q];
      id_pc    = pc_mem_q[head_q];
    end else if (bypass) begin
      id_instr = imem_rdata;
      id_pc    = resp_pc_q;
    end
  end

  // Next-state: redirect takes priority over queue push/pop and fetch advance.
  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    resp_pc_d   = resp_pc_q;
    instr_mem_d = instr_mem_q;
    pc_mem_d    = pc_mem_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    discard_d   = discard_q;
    started_d   = 1'b1;
    outst_d     = outst_q + CNT_W'(issue) - CNT_W'(rvalid_acc);

    if (pc_load) begin
      // Everything still in flight after this edge belongs to the old stream.
      fetch_pc_d = target;
      resp_pc_d  = target;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      discard_d  = outst_d;
      state_d    = (outst_d != '0) ? ST_FLUSH : ST_FETCH;
    end else begin
      if (issue) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      case (state_q)
        ST_FETCH: begin
          if (accept) begin
            resp_pc_d = resp_pc_q + 32'd4;
          end
          if (push) begin
            instr_mem_d[tail_q] = imem_rdata;
            pc_mem_d[tail_q]    = resp_pc_q;
            tail_d              = tail_q + PTR_W'(1);
          end
          if (pop) begin
            head_d = head_q + PTR_W'(1);
          end
          count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
        ST_FLUSH: begin
          if (rvalid_acc) begin
            discard_d = discard_q - CNT_W'(1);
            if (discard_d == '0) begin
              state_d = ST_FETCH;
            end
          end
        end
        default: begin
          state_d = ST_FETCH;
        end
      endcase
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_FETCH;
      fetch_pc_q  <= RESET_PC;
      resp_pc_q   <= RESET_PC;
      instr_mem_q <= '{default: 32'h0};
      pc_mem_q    <= '{default: 32'h0};
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      outst_q     <= '0;
      discard_q   <= '0;
      started_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      resp_pc_q   <= resp_pc_d;
      instr_mem_q <= instr_mem_d;
      pc_mem_q    <= pc_mem_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      outst_q     <= outst_d;
      discard_q   <= discard_d;
      started_q   <= started_d;
    end
  end

endmodule
`default_nettype wire
